bird_flight_ctrl: RTL

Game-flow and physics sequencer for the flappy-bird datapath. It sits between the debounced flap key and the `kinematics` velocity FSM. It generates the physics tick, gates when the velocity FSM advances, and feeds it the flap request. It integrates the returned signed velocity into the bird's row and runs the IDLE/PLAY/DEAD game state machine with scoring.

---
 rtl/bird_flight_ctrl.sv | 90 +++++++++
 1 files changed

// File: rtl/bird_flight_ctrl.sv
// bird_flight_ctrl: flappy-bird game-flow FSM, physics tick, flap request and row integration.
// Build option: define BIRD_FLAP_HOLD_EN to make flap follow the held key level in PLAY.
module bird_flight_ctrl #(
    parameter int TICK_DIV  = 50,
    parameter int ROWS      = 16,
    parameter int START_ROW = 8,
    parameter int RW        = $clog2(ROWS)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                key,
    input  logic                collide,
    input  logic                pipe_pass,
    input  logic signed [2:0]   velocity,
    output logic                step,
    output logic                flap,
    output logic                kin_rst,
    output logic [RW-1:0]       row,
    output logic [1:0]          state,
    output logic                dead,
    output logic [7:0]          score
);
    localparam logic [1:0] IDLE = 2'b00, PLAY = 2'b01, DEAD = 2'b10;
    localparam int CW = $clog2(TICK_DIV);
    localparam logic signed [RW+1:0] MAX_ROW = (RW+2)'(ROWS - 1);

    logic [1:0]             state_n;
    logic [CW-1:0]          cnt;
    logic                   key_q, kedge, step_d, floor_hit;
    logic signed [RW+1:0]   nxt;
    logic [RW-1:0]          row_upd;

    assign kedge     = key & ~key_q;
    assign nxt       = $signed({2'b00, row}) - (RW+2)'(velocity);
    assign floor_hit = step_d && nxt > MAX_ROW;
    assign row_upd   = nxt < 0 ? '0 : nxt > MAX_ROW ? RW'(ROWS - 1) : nxt[RW-1:0];

    // state register
    always_ff @(posedge CLK)
        state <= RST ? IDLE : state_n;

    // next-state: key edges start/restart, collide or floor kills, 11 recovers to IDLE
    always_comb
        state_n = state == IDLE ? (kedge ? PLAY : IDLE) :
                  state == PLAY ? ((collide || floor_hit) ? DEAD : PLAY) :
                  state == DEAD ? (kedge ? IDLE : DEAD) : IDLE;

    // state-decoded outputs
    always_comb begin
        kin_rst = state != PLAY;
        dead    = state == DEAD;
    end

    // key history, tick counter; step is registered one cycle ahead so it lands on the last count
    always_ff @(posedge CLK) begin
        if (RST) begin
            key_q  <= 1'b0;
            cnt    <= '0;
            step   <= 1'b0;
            step_d <= 1'b0;
        end else begin
            key_q  <= key;
            cnt    <= (state == PLAY && state_n == PLAY) ? (cnt == CW'(TICK_DIV - 1) ? '0 : cnt + 1'b1) : '0;
            step   <= state == PLAY && state_n == PLAY && cnt == CW'(TICK_DIV - 2);
            step_d <= step;
        end
    end

`ifdef BIRD_FLAP_HOLD_EN
    // flap follows the key level while playing
    always_ff @(posedge CLK)
        flap <= RST ? 1'b0 : (state_n == PLAY && key);
`else
    // flap is the pending-flap latch: key edge sets (wins over step), step consumes, DEAD exit clears
    always_ff @(posedge CLK)
        flap <= RST ? 1'b0 : kedge ? (state != DEAD) : (flap & ~step);
`endif

    // row integration after each tick, and saturating score while play continues
    always_ff @(posedge CLK) begin
        if (RST) begin
            row   <= RW'(START_ROW);
            score <= '0;
        end else begin
            row   <= state_n == IDLE ? RW'(START_ROW) : (state == PLAY && step_d) ? row_upd : row;
            score <= (state == IDLE && kedge) ? '0 :
                     (state == PLAY && state_n == PLAY && pipe_pass && score != 8'hFF) ? score + 1'b1 : score;
        end
    end
endmodule
